// File: rtl/tinymap_length_decoder_pkg.sv
// tinymap_length_decoder_pkg: shared tinymap geometry, note-length templates and decoder state type.
package tinymap_length_decoder_pkg;
    localparam int TINYMAP_ROWS = 16;
    localparam int ROW_W = 16;
    localparam int DIST_W = 9;
    typedef logic [ROW_W-1:0] row_t;
    typedef enum logic {ACCUM, RESULT} state_t;
    localparam row_t QUARTER_T [TINYMAP_ROWS] = '{
        16'h0000, 16'h0FF0, 16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE, 16'h0FF0, 16'h0000, 16'hFFFF
    };
    localparam row_t HALF_T [TINYMAP_ROWS] = '{
        16'h0000, 16'h0FF0, 16'h7FFE, 16'hFFFF, 16'hF00F, 16'hC003, 16'hFFFF, 16'hFFFF,
        16'hFFFF, 16'hC003, 16'hF00F, 16'hFFFF, 16'h7FFE, 16'h0FF0, 16'h0000, 16'hFFFF
    };
endpackage

// File: rtl/tinymap_length_decoder_if.sv
// tinymap_length_decoder_if: row stream in, classification result out.
// dist_q/dist_h exist only when LENGTH_DEC_DIST_EN is defined.
interface tinymap_length_decoder_if;
    import tinymap_length_decoder_pkg::*;
    logic frame_clr;
    logic in_valid;
    logic in_ready;
    row_t in_row;
    logic out_valid;
    logic out_ready;
    logic is_half;
    logic match;
`ifdef LENGTH_DEC_DIST_EN
    logic [DIST_W-1:0] dist_q;
    logic [DIST_W-1:0] dist_h;
    modport master (output frame_clr, in_valid, in_row, out_ready,
                    input in_ready, out_valid, is_half, match, dist_q, dist_h);
    modport slave (input frame_clr, in_valid, in_row, out_ready,
                   output in_ready, out_valid, is_half, match, dist_q, dist_h);
`else
    modport master (output frame_clr, in_valid, in_row, out_ready,
                    input in_ready, out_valid, is_half, match);
    modport slave (input frame_clr, in_valid, in_row, out_ready,
                   output in_ready, out_valid, is_half, match);
`endif
endinterface

// File: rtl/popcount16.sv
// popcount16: combinational population count of a 16-bit word.
module popcount16 (
    input  logic [15:0] d,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) cnt += 5'(d[i]);
    end
endmodule

// File: rtl/tinymap_length_decoder.sv
// tinymap_length_decoder: streams a 16x16 tinymap and picks the nearer of quarter/half templates.
// Optional LENGTH_DEC_DIST_EN exposes the final Hamming distances.
module tinymap_length_decoder
    import tinymap_length_decoder_pkg::*;
#(
    parameter int MATCH_THRESH = 24
) (
    input logic clk,
    input logic rst_n,
    tinymap_length_decoder_if.slave bus
);
    state_t state, state_d;
    logic [3:0] row;
    logic [DIST_W-1:0] acc_q, acc_h, nxt_q, nxt_h, nxt_min;
    logic [4:0] pc_q, pc_h;
    logic accept, last, done, is_half, match;

    popcount16 u_pc_q (.d(bus.in_row ^ QUARTER_T[row]), .cnt(pc_q));
    popcount16 u_pc_h (.d(bus.in_row ^ HALF_T[row]), .cnt(pc_h));

    assign bus.in_ready = rst_n && state == ACCUM;
    assign accept = bus.in_valid && bus.in_ready && !bus.frame_clr;
    assign last = accept && row == 4'(TINYMAP_ROWS - 1);
    assign done = state == RESULT && bus.out_ready && !bus.frame_clr;
    assign nxt_q = acc_q + DIST_W'(pc_q);
    assign nxt_h = acc_h + DIST_W'(pc_h);
    assign nxt_min = nxt_h < nxt_q ? nxt_h : nxt_q;

    always_comb
        state_d = bus.frame_clr ? ACCUM : last ? RESULT : done ? ACCUM : state;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ACCUM;
        else state <= state_d;

    // Row counter is 4 bits, so it wraps to 0 on the 16th row by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            acc_q <= '0;
            acc_h <= '0;
            is_half <= 1'b0;
            match <= 1'b0;
        end else if (bus.frame_clr || done) begin
            row <= '0;
            acc_q <= '0;
            acc_h <= '0;
            is_half <= 1'b0;
            match <= 1'b0;
        end else if (accept) begin
            row <= row + 4'd1;
            acc_q <= nxt_q;
            acc_h <= nxt_h;
            if (last) begin
                is_half <= nxt_h < nxt_q;
                match <= nxt_min <= DIST_W'(MATCH_THRESH);
            end
        end
    end

    assign bus.out_valid = state == RESULT;
    assign bus.is_half = is_half;
    assign bus.match = match;
`ifdef LENGTH_DEC_DIST_EN
    assign bus.dist_q = state == RESULT ? acc_q : '0;
    assign bus.dist_h = state == RESULT ? acc_h : '0;
`endif
endmodule

// File: doc/tinymap_length_decoder.md
# tinymap_length_decoder

Inverse of the note-length template generator in the match accelerator: consumes a 16x16 tinymap one row per cycle and decides whether it is a quarter-note or half-note head. The decoder accumulates the Hamming distance of the streamed tile against both built-in templates and reports the nearer one, plus a match flag gated by a distance threshold. It sits between the tile fetcher and the symbol-classification logic.

## Interface
- MATCH_THRESH, 24: maximum winning distance (inclusive) for `match`=1; range 0..256.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_clr  in  1  synchronous abort; discards the partial frame and any pending result.
- in_valid  in  1  row present on `in_row`.
- in_ready  out  1  decoder accepts a row this cycle.
- in_row  in  16  tile row; row 0 first, maps to tinymap bits [255:240]; bit 15 = tinymap MSB of that row.
- out_valid  out  1  result held stable until accepted.
- out_ready  in  1  consumer accepts result.
- is_half  out  1  1 = half note, 0 = quarter note.
- match  out  1  winning distance <= MATCH_THRESH.
- dist_q  out  9  distance to quarter template (only with LENGTH_DEC_DIST_EN).
- dist_h  out  9  distance to half template (only with LENGTH_DEC_DIST_EN).

## Operation
- Templates (rows 0..15, hex):
  - Quarter: 0000 0FF0 7FFE FFFF FFFF FFFF FFFF FFFF FFFF FFFF FFFF FFFF 7FFE 0FF0 0000 FFFF.
  - Half: 0000 0FF0 7FFE FFFF F00F C003 FFFF FFFF FFFF C003 F00F FFFF 7FFE 0FF0 0000 FFFF.
- States: ACCUM (row counter 0..15, `in_ready`=1) and RESULT (`out_valid`=1, `in_ready`=0).
- ACCUM, on `in_valid && in_ready`: `acc_q += popcount(in_row ^ Q[row])`, `acc_h += popcount(in_row ^ H[row])`, row counter +1. On row 15 accepted -> RESULT; counter wraps to 0.
- Accumulators are 9 bits unsigned; maximum 256, so no overflow.
- Result is registered on entering RESULT: `is_half = (acc_h < acc_q)` (tie resolves to quarter); `match = (min(acc_q,acc_h) <= MATCH_THRESH)`.
- RESULT, on `out_ready`: -> ACCUM, accumulators and counter cleared.
- `frame_clr` has priority over every handshake. In any state it forces ACCUM with the counter and accumulators cleared and `out_valid`=0. A row offered in the same cycle is dropped.
- Reset: state ACCUM, counter 0, accumulators 0; `in_ready`=0 while rst_n low, then 1. `out_valid`, `is_half`, `match`, `dist_q`, `dist_h` all 0.

## Timing
- One row per cycle at full throughput; 16 accepted rows -> `out_valid` rises the cycle after the 16th handshake.
- Minimum frame period is 17 cycles: 16 rows plus 1 result cycle with same-cycle `out_ready`. `in_ready` returns high the cycle after the result handshake.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- Gaps (`in_valid`=0) stall accumulation without losing state.

## Configuration
- LENGTH_DEC_DIST_EN defined: `dist_q`/`dist_h` ports exist and show the final accumulator values while `out_valid`=1; they are 0 otherwise.
- Undefined: the ports are absent and the distances are internal only. `is_half`/`match` behaviour is identical.

## Structure
- Shared package holds the two 16x16-bit template constant arrays, TINYMAP_ROWS=16, ROW_W=16 and DIST_W=9, so the template generator and this decoder share one source.
- One sub-module: `popcount16`, a combinational 16-bit to 5-bit population count, instantiated twice.

## Test plan
- Stream the exact Quarter template, `out_ready`=1 -> `out_valid` at cycle 17; `is_half`=0, `match`=1, dist_q=0, dist_h=40.
- Stream the exact Half template -> `is_half`=1, `match`=1, dist_h=0, dist_q=40.
- All-zero frame -> dist_q=204, dist_h=164, `is_half`=1, `match`=0.
- Tie: Quarter frame with rows 4,5 replaced by F00F,C003 -> dist_q=20, dist_h=20, `is_half`=0, `match`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles -> `in_ready`=0 and outputs frozen; handshake -> next frame accepted, distances start from 0.
- Abort: assert `frame_clr` with `in_valid` after 7 rows, then stream a full Half frame. Expect result dist_h=0, i.e. no residue from the partial frame. Also drop rst_n mid-frame -> all outputs 0 immediately.
